alu_arbiter: RTL and testbench

Shares the single 8-bit combinational ALU between NREQ requesters, for example the execute stage and the branch/address unit.
- Round-robin arbitration over valid/ready request channels.
- Registers the winning operation, drives the external ALU from that register, and captures the result and flags into a response register.
- Response channel carries requester id and supports backpressure.
- Sits between the control/datapath requesters and the ALU instance.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_arbiter_rr.sv | 34 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag and request definitions for the ALU arbiter.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_LSL = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;

    // Flag vector layout {C,N,Z}
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    // Flags reported for an undefined opcode: only Z set
    localparam logic [2:0] ERR_FLAGS = 3'(1 << FLG_Z);

    // One ALU operation as held in the issue stage
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } alu_req_t;

    // Defined opcodes are the contiguous range ADD..NOT; NOP and 1011..1111 are errors
    function automatic logic op_defined(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   pos;

    // Scan offsets 0..NREQ-1 from ptr; the first hit wins and blocks the rest
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == pos) && req[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU among NREQ requesters through a
// two-stage (ISSUE -> RSP) pipeline with round-robin arbitration and a
// backpressured response channel tagged with the requester id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_op,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [3:0]           alu_op_o,
    output logic [7:0]           alu_a_o,
    output logic [7:0]           alu_b_o,
    output logic                 alu_cin_o,
    input  logic [7:0]           alu_out_i,
    input  logic [2:0]           alu_flags_i,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_out,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy
);

    logic            issue_v;
    alu_req_t        issue;
    logic [IDW-1:0]  issue_id;
    logic            rsp_v;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  rr_next;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    alu_req_t        sel;
    logic            rsp_adv;
    logic            can_accept;
    logic            accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // The issue entry moves on when RSP is empty or draining; a slot frees up
    // in the same cycle, so back-to-back issue runs at one op per cycle.
    assign rsp_adv    = issue_v & (~rsp_v | rsp_ready);
    assign can_accept = ~issue_v | rsp_adv;

    // rst_n gates ready so it drops the instant reset is asserted
    assign req_ready  = grant & {NREQ{can_accept & rst_n}};
    assign accept     = |req_ready;

    // Pointer moves just past the winner so it has lowest priority next time
    assign rr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // One-hot mux of the granted requester's operation fields
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.op  = req_op[4*i +: 4];
                sel.a   = req_a[8*i +: 8];
                sel.b   = req_b[8*i +: 8];
                sel.cin = req_cin[i];
            end
        end
    end

    // ISSUE stage and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_v  <= 1'b0;
            issue    <= '0;
            issue_id <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            issue_v  <= 1'b1;
            issue    <= sel;
            issue_id <= grant_idx;
            rr_ptr   <= rr_next;
        end else if (rsp_adv) begin
            issue_v  <= 1'b0;
        end
    end

    // RSP stage: capture the ALU result, or the fixed error pattern for undefined ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v     <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else if (rsp_adv) begin
            rsp_v  <= 1'b1;
            rsp_id <= issue_id;
            if (op_defined(issue.op)) begin
                rsp_out   <= alu_out_i;
                rsp_flags <= alu_flags_i;
                rsp_err   <= 1'b0;
            end else begin
                rsp_out   <= 8'h00;
                rsp_flags <= ERR_FLAGS;
                rsp_err   <= 1'b1;
            end
        end else if (rsp_v && rsp_ready) begin
            rsp_v <= 1'b0;
        end
    end

    assign alu_op_o  = issue.op;
    assign alu_a_o   = issue.a;
    assign alu_b_o   = issue.b;
    assign alu_cin_o = issue.cin;
    assign rsp_valid = rsp_v;
    assign busy      = issue_v | rsp_v;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic, with a queue-based reference model of in-flight operations.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*4-1:0]    req_op;
    logic [NREQ*8-1:0]    req_a;
    logic [NREQ*8-1:0]    req_b;
    logic [NREQ-1:0]      req_cin;
    logic [3:0]           alu_op_o;
    logic [7:0]           alu_a_o;
    logic [7:0]           alu_b_o;
    logic                 alu_cin_o;
    logic [7:0]           alu_out_i;
    logic [2:0]           alu_flags_i;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_out;
    logic [2:0]           rsp_flags;
    logic                 rsp_err;
    logic                 busy;

    logic [3:0] op_v [NREQ];
    logic [7:0] a_v  [NREQ];
    logic [7:0] b_v  [NREQ];

    int passed = 0;
    int total  = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_cin_o(alu_cin_o),
        .alu_out_i(alu_out_i), .alu_flags_i(alu_flags_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural external ALU: returns {C,N,Z,out}; undefined ops yield junk
    function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = '0; r = '0; c = 1'b0;
        case (op)
            4'd1:  begin s = {1'b0, a} + {1'b0, b} + {8'b0, cin}; r = s[7:0]; c = s[8]; end
            4'd2:  begin s = {1'b0, a} - {1'b0, b} - {8'b0, cin}; r = s[7:0]; c = s[8]; end
            4'd3:  begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd4:  begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd5:  begin r = {a[6:0], a[7]}; c = a[7]; end
            4'd6:  begin r = {a[0], a[7:1]}; c = a[0]; end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: r = ~a;
            default: return {3'b110, a ^ b};
        endcase
        return {c, r[7], (r == 8'h00), r};
    endfunction

    // Expected response {err, flags, out} for one request
    function automatic logic [11:0] exp_rsp(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
        if (op >= 4'd1 && op <= 4'd10) return {1'b0, alu_fn(op, a, b, cin)};
        return {1'b1, 3'b001, 8'h00};
    endfunction

    always_comb begin
        {alu_flags_i, alu_out_i} = alu_fn(alu_op_o, alu_a_o, alu_b_o, alu_cin_o);
    end

    always_comb begin
        req_op = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[4*i +: 4] = op_v[i];
            req_a[8*i +: 8]  = a_v[i];
            req_b[8*i +: 8]  = b_v[i];
        end
    end

    // Reference model: FIFO of accepted ops (at most two in flight), rr pointer, edge count
    typedef struct {
        logic [IDW-1:0] id;
        logic [11:0]    r;
        int             acc;
    } ent_t;
    ent_t           q[$];
    logic [IDW-1:0] mptr   = '0;
    int             ecount = 0;

    // Scoreboard samples 2 time units before every rising edge
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        logic [IDW-1:0]  gsel;
        int              gi;
        int              j;
        ent_t            e;
        #3;
        if (!rst_n) begin
            q.delete();
            mptr = '0;
            total++;
            if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL sb_reset: ready=%b rsp_valid=%b busy=%b want 0/0/0",
                         req_ready, rsp_valid, busy);
            else passed++;
        end else begin
            exp_rdy = '0;
            gi = -1;
            if (q.size() < 2 || rsp_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = int'(mptr) + k;
                    if (j >= NREQ) j = j - NREQ;
                    if (gi < 0 && req_valid[IDW'(j)]) gi = j;
                end
            end
            gsel = IDW'(gi);
            if (gi >= 0) exp_rdy[gsel] = 1'b1;
            exp_rv = (q.size() > 0) && (ecount >= q[0].acc + 2);

            total++;
            if (req_ready !== exp_rdy)
                $display("FAIL sb_ready: got %b want %b (t=%0t)", req_ready, exp_rdy, $time);
            else passed++;

            total++;
            if (rsp_valid !== exp_rv || busy !== (q.size() > 0))
                $display("FAIL sb_valid: rsp_valid=%b busy=%b want %b/%b (t=%0t)",
                         rsp_valid, busy, exp_rv, (q.size() > 0), $time);
            else passed++;

            if (exp_rv && rsp_ready) begin
                total++;
                if (rsp_id !== q[0].id || {rsp_err, rsp_flags, rsp_out} !== q[0].r)
                    $display("FAIL sb_rsp: id=%0d data=%h want id=%0d data=%h (t=%0t)",
                             rsp_id, {rsp_err, rsp_flags, rsp_out}, q[0].id, q[0].r, $time);
                else passed++;
                void'(q.pop_front());
            end
            if (gi >= 0) begin
                e.id  = gsel;
                e.r   = exp_rsp(op_v[gsel], a_v[gsel], b_v[gsel], req_cin[gsel]);
                e.acc = ecount;
                q.push_back(e);
                mptr = (gi == NREQ - 1) ? '0 : IDW'(gi + 1);
            end
        end
        ecount++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic cin);
        op_v[i] = op; a_v[i] = a; b_v[i] = b; req_cin[i] = cin;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_req(0, 4'd1, 8'h12, 8'h34, 1'b0);
        set_req(1, 4'd2, 8'h56, 8'h78, 1'b1);
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({alu_op_o, alu_a_o, alu_b_o, alu_cin_o} !== 21'd0)
            $display("FAIL reset_alu: got %h want 0", {alu_op_o, alu_a_o, alu_b_o, alu_cin_o});
        else passed++;
        total++;
        if ({rsp_id, rsp_out, rsp_flags, rsp_err} !== 13'd0)
            $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_out, rsp_flags, rsp_err});
        else passed++;
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctl: ready=%b rsp_valid=%b busy=%b want 00/0/0",
                     req_ready, rsp_valid, busy);
        else passed++;
        step();
        step();
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        step();
        set_req(0, 4'd1, 8'hF0, 8'h20, 1'b0);
        req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL add_ready: got %b want 01", req_ready);
        else passed++;
        step();
        req_valid = 2'b00;
        #1;
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL add_early: rsp_valid=%b want 0", rsp_valid);
        else passed++;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 8'h10 ||
            rsp_flags !== 3'b100 || rsp_err !== 1'b0)
            $display("FAIL add_rsp: v=%b id=%0d out=%h fl=%b err=%b want 1/0/10/100/0",
                     rsp_valid, rsp_id, rsp_out, rsp_flags, rsp_err);
        else passed++;
    endtask

    task automatic test_sub();
        logic [7:0] bv [2] = '{8'h05, 8'h05};
        logic [7:0] av [2] = '{8'h03, 8'h05};
        logic [10:0] want [2] = '{{3'b110, 8'hFE}, {3'b001, 8'h00}};
        for (int n = 0; n < 2; n++) begin
            step();
            set_req(1, 4'd2, av[n], bv[n], 1'b0);
            req_valid = 2'b10;
            #1;
            total++;
            if (req_ready !== 2'b10) $display("FAIL sub_ready%0d: got %b want 10", n, req_ready);
            else passed++;
            step();
            req_valid = 2'b00;
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_flags, rsp_out} !== want[n] ||
                rsp_err !== 1'b0)
                $display("FAIL sub_rsp%0d: v=%b id=%0d fl/out=%h err=%b want 1/1/%h/0",
                         n, rsp_valid, rsp_id, {rsp_flags, rsp_out}, rsp_err, want[n]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int grants[$];
        int rids[$];
        int rcyc[$];
        logic [NREQ-1:0] g;
        logic rv;
        logic [IDW-1:0] rid;
        int acc = 0;
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 4'($urandom_range(1, 10)), 8'($urandom), 8'($urandom), 1'($urandom));
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 30 && rids.size() < 8; cyc++) begin
            #1;
            g = req_ready; rv = rsp_valid; rid = rsp_id;
            step();
            if (g != 0) begin
                grants.push_back(g[1] ? 1 : 0);
                acc++;
                set_req(g[1] ? 1 : 0, 4'($urandom_range(1, 10)), 8'($urandom), 8'($urandom),
                        1'($urandom));
                if (acc == 8) req_valid = 2'b00;
            end
            if (rv) begin
                rids.push_back(int'(rid));
                rcyc.push_back(cyc);
            end
        end
        total++;
        if (grants.size() != 8 || rids.size() != 8)
            $display("FAIL b2b_count: grants=%0d rsps=%0d want 8/8", grants.size(), rids.size());
        else begin
            passed++;
            for (int k = 0; k < 8; k++) begin
                total++;
                if (grants[k] != k % 2 || rids[k] != k % 2)
                    $display("FAIL b2b_order%0d: grant=%0d rsp_id=%0d want %0d", k, grants[k],
                             rids[k], k % 2);
                else passed++;
            end
            total++;
            if (rcyc[7] - rcyc[0] != 7)
                $display("FAIL b2b_gap: span=%0d want 7", rcyc[7] - rcyc[0]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] w0, w1;
        logic [12:0] snap;
        step();
        rsp_ready = 1'b0;
        set_req(0, 4'd9, 8'hA5, 8'h0F, 1'b0);
        set_req(1, 4'd1, 8'h7F, 8'h01, 1'b1);
        w0 = exp_rsp(4'd9, 8'hA5, 8'h0F, 1'b0);
        w1 = exp_rsp(4'd1, 8'h7F, 8'h01, 1'b1);
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL bp_first: got %b want 01", req_ready);
        else passed++;
        step();
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) $display("FAIL bp_second: got %b want 10", req_ready);
        else passed++;
        step();
        req_valid = 2'b11;
        #1;
        snap = {rsp_id, rsp_err, rsp_flags, rsp_out};
        total++;
        if (rsp_valid !== 1'b1 || snap !== {1'b0, w0} || req_ready !== 2'b00)
            $display("FAIL bp_full: v=%b rsp=%h ready=%b want 1/%h/00", rsp_valid, snap,
                     req_ready, {1'b0, w0});
        else passed++;
        for (int n = 0; n < 3; n++) begin
            step();
            total++;
            if ({rsp_id, rsp_err, rsp_flags, rsp_out} !== snap || rsp_valid !== 1'b1 ||
                req_ready !== 2'b00 || busy !== 1'b1)
                $display("FAIL bp_hold%0d: rsp=%h v=%b ready=%b busy=%b want %h/1/00/1", n,
                         {rsp_id, rsp_err, rsp_flags, rsp_out}, rsp_valid, req_ready, busy, snap);
            else passed++;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        total++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_err, rsp_flags, rsp_out} !== {1'b1, w1})
            $display("FAIL bp_drain: v=%b rsp=%h want 1/%h", rsp_valid,
                     {rsp_id, rsp_err, rsp_flags, rsp_out}, {1'b1, w1});
        else passed++;
        step();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_empty: v=%b busy=%b want 0/0", rsp_valid, busy);
        else passed++;
    endtask

    task automatic test_error();
        step();
        set_req(0, 4'hF, 8'h55, 8'hAA, 1'b0);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 8'h00 ||
            rsp_flags !== 3'b001 || rsp_err !== 1'b1)
            $display("FAIL err_rsp: v=%b id=%0d out=%h fl=%b err=%b want 1/0/00/001/1",
                     rsp_valid, rsp_id, rsp_out, rsp_flags, rsp_err);
        else passed++;
        step();
        set_req(1, 4'd1, 8'h01, 8'h01, 1'b0);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 8'h02 ||
            rsp_flags !== 3'b000 || rsp_err !== 1'b0)
            $display("FAIL err_next: v=%b id=%0d out=%h fl=%b err=%b want 1/1/02/000/0",
                     rsp_valid, rsp_id, rsp_out, rsp_flags, rsp_err);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step();
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++)
                set_req(i, 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        step();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        step();
        step();
        total++;
        if (busy !== 1'b0 || q.size() != 0)
            $display("FAIL rand_drain: busy=%b model_left=%0d want 0/0", busy, q.size());
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [11:0] w;
        step();
        rsp_ready = 1'b0;
        set_req(0, 4'd7, 8'hCC, 8'h0F, 1'b0);
        set_req(1, 4'd8, 8'h30, 8'h03, 1'b0);
        req_valid = 2'b11;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00 || alu_op_o !== 4'd0)
            $display("FAIL arst_drop: v=%b busy=%b ready=%b op=%h want 0/0/00/0",
                     rsp_valid, busy, req_ready, alu_op_o);
        else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 4'd1, 8'h11, 8'h22, 1'b0);
        w = exp_rsp(4'd1, 8'h11, 8'h22, 1'b0);
        #1;
        total++;
        if (req_ready !== 2'b01 || rsp_valid !== 1'b0)
            $display("FAIL arst_ptr: ready=%b v=%b want 01/0", req_ready, rsp_valid);
        else passed++;
        step();
        req_valid = 2'b00;
        #1;
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL arst_stale: v=%b want 0", rsp_valid);
        else passed++;
        step();
        total++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_err, rsp_flags, rsp_out} !== {1'b0, w})
            $display("FAIL arst_first: v=%b rsp=%h want 1/%h", rsp_valid,
                     {rsp_id, rsp_err, rsp_flags, rsp_out}, {1'b0, w});
        else passed++;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
